// File: rtl/pulse_monitor_if.sv
// pulse_monitor_if: groups the measurement inputs and results of pulse_monitor.
//   master : the driver of the pulse train and the consumer of the results.
//   slave  : the monitor itself.
// Signals:
//   clear        - synchronous statistics clear
//   pulse_in     - pulse train under measurement
//   meas_valid   - one-cycle strobe, width measurement completed
//   gap_valid    - one-cycle strobe, gap measurement completed
//   last_width   - high time of the last complete pulse (cycles)
//   last_gap     - low time preceding the last rising edge (cycles)
//   min_width    - smallest width since reset/clear (all-ones when none)
//   max_width    - largest width since reset/clear
//   pulse_count  - completed pulses since reset/clear, saturating
//   overflow     - sticky, a width or gap counter saturated
//   activity_led - stretched activity indicator
interface pulse_monitor_if #(
    parameter int CNT_W   = 32,
    parameter int COUNT_W = 16
);
    logic               clear;
    logic               pulse_in;
    logic               meas_valid;
    logic               gap_valid;
    logic [CNT_W-1:0]   last_width;
    logic [CNT_W-1:0]   last_gap;
    logic [CNT_W-1:0]   min_width;
    logic [CNT_W-1:0]   max_width;
    logic [COUNT_W-1:0] pulse_count;
    logic               overflow;
    logic               activity_led;

    modport master (
        output clear, pulse_in,
        input  meas_valid, gap_valid, last_width, last_gap, min_width,
               max_width, pulse_count, overflow, activity_led
    );

    modport slave (
        input  clear, pulse_in,
        output meas_valid, gap_valid, last_width, last_gap, min_width,
               max_width, pulse_count, overflow, activity_led
    );
endinterface

// File: rtl/pulse_monitor.sv
// pulse_monitor: measures high width and low gap of a pulse train, keeps
// min/max/count statistics, a sticky overflow flag and a stretched LED.
// Ports:
//   clk     - clock
//   reset_n - asynchronous active-low reset
//   mon     - pulse_monitor_if.slave (clear, pulse_in in; results out)
// Parameters: CNT_W (width/gap counters), COUNT_W (pulse_count width),
//   LED_STRETCH (cycles activity_led stays on after a measurement, >= 1).
// Build option: define PULSE_MONITOR_SYNC_EN to pass pulse_in through a
//   two-flop synchronizer (adds 2 cycles of strobe latency, widths unchanged).
module pulse_monitor #(
    parameter int CNT_W       = 32,
    parameter int COUNT_W     = 16,
    parameter int LED_STRETCH = 50_000_000
) (
    input logic          clk,
    input logic          reset_n,
    pulse_monitor_if.slave mon
);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [COUNT_W-1:0] PCNT_MAX = '1;
    localparam int                 LED_W    = $clog2(LED_STRETCH + 1);
    localparam logic [LED_W-1:0]   LED_LOAD = LED_W'(LED_STRETCH);

    typedef enum logic [1:0] {SYNC, IDLE_LOW, HIGH, LOW} state_t;

    state_t           state, state_nxt;
    logic             in_s;
    logic             cap_width, cap_gap;
    logic [CNT_W-1:0] hi_cnt, lo_cnt, hi_inc, lo_inc;
    logic [LED_W-1:0] led_cnt;

`ifdef PULSE_MONITOR_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], mon.pulse_in};
    end
    assign in_s = sync_q[1];
`else
    assign in_s = mon.pulse_in;
`endif

    // Saturating increments; reaching all-ones is what flags overflow.
    assign hi_inc = hi_cnt + CNT_W'(hi_cnt != CNT_MAX);
    assign lo_inc = lo_cnt + CNT_W'(lo_cnt != CNT_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= SYNC;
        else          state <= state_nxt;
    end

    // clear overrides every transition, so an edge coinciding with clear
    // produces no capture.
    always_comb begin
        state_nxt = state;
        cap_width = 1'b0;
        cap_gap   = 1'b0;
        if (mon.clear) begin
            state_nxt = SYNC;
        end else begin
            case (state)
                SYNC:     if (!in_s) state_nxt = IDLE_LOW;
                IDLE_LOW: if (in_s)  state_nxt = HIGH;
                HIGH: if (!in_s) begin
                    state_nxt = LOW;
                    cap_width = 1'b1;
                end
                LOW: if (in_s) begin
                    state_nxt = HIGH;
                    cap_gap   = 1'b1;
                end
                default:  state_nxt = SYNC;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_cnt           <= '0;
            lo_cnt           <= '0;
            led_cnt          <= '0;
            mon.meas_valid   <= 1'b0;
            mon.gap_valid    <= 1'b0;
            mon.last_width   <= '0;
            mon.last_gap     <= '0;
            mon.min_width    <= CNT_MAX;
            mon.max_width    <= '0;
            mon.pulse_count  <= '0;
            mon.overflow     <= 1'b0;
            mon.activity_led <= 1'b0;
        end else begin
            mon.meas_valid <= 1'b0;
            mon.gap_valid  <= 1'b0;
            if (mon.clear) begin
                led_cnt          <= '0;
                mon.last_width   <= '0;
                mon.last_gap     <= '0;
                mon.min_width    <= CNT_MAX;
                mon.max_width    <= '0;
                mon.pulse_count  <= '0;
                mon.overflow     <= 1'b0;
                mon.activity_led <= 1'b0;
            end else begin
                case (state)
                    IDLE_LOW: if (in_s) hi_cnt <= CNT_W'(1);
                    HIGH: begin
                        if (in_s) begin
                            hi_cnt <= hi_inc;
                            if (hi_inc == CNT_MAX) mon.overflow <= 1'b1;
                        end else begin
                            lo_cnt <= CNT_W'(1);
                        end
                    end
                    LOW: begin
                        if (!in_s) begin
                            lo_cnt <= lo_inc;
                            if (lo_inc == CNT_MAX) mon.overflow <= 1'b1;
                        end else begin
                            hi_cnt <= CNT_W'(1);
                        end
                    end
                    default: ;
                endcase

                if (cap_width) begin
                    mon.last_width <= hi_cnt;
                    mon.meas_valid <= 1'b1;
                    if (mon.pulse_count != PCNT_MAX)
                        mon.pulse_count <= mon.pulse_count + COUNT_W'(1);
                    if (hi_cnt < mon.min_width) mon.min_width <= hi_cnt;
                    if (hi_cnt > mon.max_width) mon.max_width <= hi_cnt;
                end

                if (cap_gap) begin
                    mon.last_gap  <= lo_cnt;
                    mon.gap_valid <= 1'b1;
                end

                // LED register mirrors (led_cnt != 0) one cycle ahead so the
                // output itself is a flop and rises with meas_valid.
                if (cap_width) begin
                    led_cnt          <= LED_LOAD;
                    mon.activity_led <= 1'b1;
                end else if (led_cnt != '0) begin
                    led_cnt          <= led_cnt - LED_W'(1);
                    mon.activity_led <= (led_cnt != LED_W'(1));
                end
            end
        end
    end
endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: directed scenarios plus randomized pulse trains against a
// run-length model of the monitor. Small parameters (4-bit counters, 8-cycle
// LED) make saturation and stretch behaviour reachable in short runs.
module tb_pulse_monitor;
    localparam int CNT_W   = 4;
    localparam int COUNT_W = 4;
    localparam int LED     = 8;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int PMAX    = (1 << COUNT_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pulse_monitor_if #(.CNT_W(CNT_W), .COUNT_W(COUNT_W)) mon ();

    pulse_monitor #(.CNT_W(CNT_W), .COUNT_W(COUNT_W), .LED_STRETCH(LED)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mon     (mon)
    );

    int tot = 0;
    int pass = 0;
    int n_meas = 0, n_gap = 0, n_led = 0;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tot++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Model: the input is viewed as a sequence of runs of equal level. A run
    // is "valid" when its start was observed after reset/clear; only valid
    // runs are measured. High runs are always valid (they start after an
    // observed low); a low run is valid only if the high run before it was.
    int m_level = 1, m_valid = 0, m_run = 0, m_led = 0;
    int exp_mv = 0, exp_gv = 0, exp_lw = 0, exp_lg = 0;
    int exp_min = CMAX, exp_max = 0, exp_cnt = 0, exp_ovf = 0;
    bit d1 = 0, d2 = 0;

    task automatic model_reset();
        m_level = 1; m_valid = 0; m_run = 0; m_led = 0;
        exp_mv = 0; exp_gv = 0; exp_lw = 0; exp_lg = 0;
        exp_min = CMAX; exp_max = 0; exp_cnt = 0; exp_ovf = 0;
        d1 = 0; d2 = 0;
    endtask

    task automatic model_step(bit pin, bit clr);
        int v;
`ifdef PULSE_MONITOR_SYNC_EN
        v = d2; d2 = d1; d1 = pin;
`else
        v = pin;
`endif
        exp_mv = 0; exp_gv = 0;
        if (clr) begin
            exp_lw = 0; exp_lg = 0; exp_min = CMAX; exp_max = 0;
            exp_cnt = 0; exp_ovf = 0; m_led = 0;
            m_level = 1; m_valid = 0;
            return;
        end
        if (v != m_level) begin
            if (m_valid != 0 && m_level == 1) begin
                exp_lw = m_run; exp_mv = 1;
                if (exp_cnt < PMAX) exp_cnt++;
                if (m_run < exp_min) exp_min = m_run;
                if (m_run > exp_max) exp_max = m_run;
                m_led = LED;
            end else if (m_valid != 0 && m_level == 0) begin
                exp_lg = m_run; exp_gv = 1;
            end
            if (m_level == 0) m_valid = 1;
            m_level = v; m_run = 1;
        end else begin
            if (m_run < CMAX) m_run++;
            if (m_valid != 0 && m_run == CMAX) exp_ovf = 1;
        end
        if (exp_mv == 0 && m_led > 0) m_led--;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step(mon.pulse_in, mon.clear);
    end

    task automatic count_strobes();
        if (mon.meas_valid)   n_meas++;
        if (mon.gap_valid)    n_gap++;
        if (mon.activity_led) n_led++;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("meas_valid",   mon.meas_valid,   exp_mv);
        check("gap_valid",    mon.gap_valid,    exp_gv);
        check("last_width",   mon.last_width,   exp_lw);
        check("last_gap",     mon.last_gap,     exp_lg);
        check("min_width",    mon.min_width,    exp_min);
        check("max_width",    mon.max_width,    exp_max);
        check("pulse_count",  mon.pulse_count,  exp_cnt);
        check("overflow",     mon.overflow,     exp_ovf);
        check("activity_led", mon.activity_led, m_led > 0);
        count_strobes();
    end

    task automatic run(bit v, int n);
        mon.pulse_in = v;
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic do_reset(bit pin_at_release);
        @(posedge clk); #2;
        reset_n   = 1'b0;
        mon.clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mon.pulse_in = i[0];
            @(posedge clk); #2;
        end
        settle();
        check("rst_min_width",   mon.min_width,   CMAX);
        check("rst_pulse_count", mon.pulse_count, 0);
        check("rst_meas_valid",  mon.meas_valid,  0);
        @(posedge clk); #2;
        mon.pulse_in = pin_at_release;
        reset_n = 1'b1;
        n_meas = 0; n_gap = 0; n_led = 0;
    endtask

    task automatic pulse_clear(bit pin);
        mon.pulse_in = pin;
        mon.clear = 1'b1;
        @(posedge clk); #2;
        mon.clear = 1'b0;
    endtask

    initial begin
        int lvl;
        mon.clear = 1'b0;
        mon.pulse_in = 1'b0;

        // Normal train
        do_reset(1'b0);
        run(0, 3); run(1, 5); run(0, 10); run(1, 5); run(0, 2);
        settle();
        check("train_meas_cnt", n_meas, 2);
        check("train_gap_cnt",  n_gap, 1);
        check("train_last_gap", mon.last_gap, 10);
        check("train_width",    mon.last_width, 5);
        check("train_count",    mon.pulse_count, 2);
        check("train_min",      mon.min_width, 5);
        check("train_max",      mon.max_width, 5);

        // Partial pulse at reset release
        do_reset(1'b1);
        run(1, 3); run(0, 4); run(1, 1); run(0, 1);
        settle();
        check("partial_meas_cnt", n_meas, 1);
        check("partial_gap_cnt",  n_gap, 0);
        check("partial_width",    mon.last_width, 1);
        check("partial_count",    mon.pulse_count, 1);

        // Saturation of the width counter
        do_reset(1'b0);
        run(0, 2); run(1, 20); run(0, 2);
        settle();
        check("sat_width",    mon.last_width, 15);
        check("sat_overflow", mon.overflow, 1);
        run(1, 3); run(0, 2);
        settle();
        check("sat_width2",      mon.last_width, 3);
        check("sat_overflow_st", mon.overflow, 1);

        // clear on the falling-edge sample, then clear during a high pulse
        do_reset(1'b0);
        run(0, 2); run(1, 3);
        pulse_clear(1'b0);
        settle();
        check("clr_meas_valid", mon.meas_valid, 0);
        check("clr_count",      mon.pulse_count, 0);
        check("clr_min",        mon.min_width, CMAX);
        run(0, 2); run(1, 3);
        pulse_clear(1'b1);
        run(1, 2); run(0, 3);
        settle();
        check("clr_discard_meas", n_meas, 0);
        check("clr_discard_cnt",  mon.pulse_count, 0);

        // LED stretch: single pulse, then retrigger 6 cycles after first strobe
        do_reset(1'b0);
        run(0, 2); run(1, 3); run(0, 20);
        settle();
        check("led_single", n_led, 8);
        n_led = 0;
        run(1, 2); run(0, 4); run(1, 2); run(0, 20);
        settle();
        check("led_retrig", n_led, 14);
        check("led_meas_cnt", n_meas, 3);

        // Randomized trains with occasional clear and reset
        do_reset(1'b0);
        lvl = 0;
        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                pulse_clear(1'($urandom_range(0, 1)));
            end else if (r < 5) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                lvl = 1 - lvl;
                run(1'(lvl), (r < 15) ? $urandom_range(14, 22) : $urandom_range(1, 6));
            end
        end
        run(0, 12);
        settle();

        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end
endmodule
